alu_op_sequencer: RTL and testbench

Command-driven front end for the 8-bit combinational ALU. It accepts one operation per valid/ready handshake and reads operands from a small internal register file or an immediate. It drives the ALU's A, B and select inputs from registers, then captures the 8-bit result and the C/Z/S/P flags. It writes the result back and returns it on a response handshake. It sits directly upstream of the ALU, feeding it, and also consumes its outputs.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_regfile.sv | 37 +++
 rtl/alu_op_sequencer.sv | 115 +++++++++++
 tb/tb_alu_op_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU front end: select codes, sequencer
// FSM states and flag bit positions within the {C,Z,S,P} flag vector.
package alu_pkg;

  // The 16 ALU select codes. Codes with bit 3 clear do not define Z/S/P.
  typedef enum logic [3:0] {
    OP_ZERO  = 4'h0,
    OP_PASSB = 4'h1,
    OP_NOTB  = 4'h2,
    OP_PASSA = 4'h3,
    OP_NOTA  = 4'h4,
    OP_INC   = 4'h5,
    OP_DEC   = 4'h6,
    OP_SHL   = 4'h7,
    OP_ADD   = 4'h8,
    OP_SUB   = 4'h9,
    OP_ADC   = 4'hA,
    OP_SBB   = 4'hB,
    OP_AND   = 4'hC,
    OP_OR    = 4'hD,
    OP_XOR   = 4'hE,
    OP_XNOR  = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } seq_state_e;

  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_S = 1;
  localparam int unsigned FLAG_P = 0;

endpackage

// File: rtl/alu_regfile.sv
// REG_COUNT x 8-bit register file: two asynchronous read ports, one
// synchronous write port, asynchronous clear.
module alu_regfile #(
  parameter int unsigned REG_COUNT = 4,
  parameter int unsigned RA_W      = $clog2(REG_COUNT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] ra_addr,
  output logic [7:0]      ra_data,
  input  logic [RA_W-1:0] rb_addr,
  output logic [7:0]      rb_data,
  input  logic            we,
  input  logic [RA_W-1:0] waddr,
  input  logic [7:0]      wdata
);

  logic [7:0] regs [REG_COUNT];

  // Storage: cleared on reset, single write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports are combinational so operands are sampled at accept time.
  always_comb begin
    ra_data = regs[ra_addr];
    rb_data = regs[rb_addr];
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-driven front end for the 8-bit combinational ALU. Accepts one
// operation per handshake, drives registered operands/select into the ALU,
// captures result and flags one cycle later, optionally writes back, and
// returns the result on a response handshake.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned REG_COUNT = 4,
  parameter int unsigned RA_W      = $clog2(REG_COUNT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [3:0]      cmd_op,
  input  logic [RA_W-1:0] cmd_ra,
  input  logic [RA_W-1:0] cmd_rb,
  input  logic            cmd_imm_en,
  input  logic [7:0]      cmd_imm,
  input  logic [RA_W-1:0] cmd_rd,
  input  logic            cmd_wb,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic [3:0]      alu_sl,
  input  logic [7:0]      alu_su,
  input  logic            alu_c,
  input  logic            alu_z,
  input  logic            alu_s,
  input  logic            alu_p,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [7:0]      rsp_data,
  output logic [3:0]      flags
);

  seq_state_e      state_q;
  logic [RA_W-1:0] rd_q;
  logic            wb_q;
  logic [7:0]      rf_a_data;
  logic [7:0]      rf_b_data;
  logic            rf_we;

  // Write-back lands at the end of EXEC, before IDLE is re-entered, so the
  // next command's operand read already sees it.
  always_comb begin
    rf_we     = (state_q == StExec) && wb_q;
    cmd_ready = (state_q == StIdle);
  end

  alu_regfile #(
    .REG_COUNT(REG_COUNT),
    .RA_W     (RA_W)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .ra_addr(cmd_ra),
    .ra_data(rf_a_data),
    .rb_addr(cmd_rb),
    .rb_data(rf_b_data),
    .we     (rf_we),
    .waddr  (rd_q),
    .wdata  (alu_su)
  );

  // Sequencer FSM with registered ALU inputs, response and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rd_q      <= '0;
      wb_q      <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sl    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      flags     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            alu_a   <= rf_a_data;
            alu_b   <= cmd_imm_en ? cmd_imm : rf_b_data;
            alu_sl  <= cmd_op;
            rd_q    <= cmd_rd;
            wb_q    <= cmd_wb;
            state_q <= StExec;
          end
        end
        StExec: begin
          rsp_data      <= alu_su;
          flags[FLAG_C] <= alu_c;
          // Z/S/P are undefined by the ALU for select codes 0-7; keep old values.
          if (alu_sl[3]) begin
            flags[FLAG_Z] <= alu_z;
            flags[FLAG_S] <= alu_s;
            flags[FLAG_P] <= alu_p;
          end
          rsp_valid <= 1'b1;
          state_q   <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with a behavioural ALU
// and a reference model feeding an expected-response queue.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int unsigned REG_COUNT = 4;
  localparam int unsigned RA_W      = 2;

  logic            clk;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [3:0]      cmd_op;
  logic [RA_W-1:0] cmd_ra;
  logic [RA_W-1:0] cmd_rb;
  logic            cmd_imm_en;
  logic [7:0]      cmd_imm;
  logic [RA_W-1:0] cmd_rd;
  logic            cmd_wb;
  logic [7:0]      alu_a;
  logic [7:0]      alu_b;
  logic [3:0]      alu_sl;
  logic [7:0]      alu_su;
  logic            alu_c;
  logic            alu_z;
  logic            alu_s;
  logic            alu_p;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [7:0]      rsp_data;
  logic [3:0]      flags;
  logic [8:0]      alu_cs;

  alu_op_sequencer #(
    .REG_COUNT(REG_COUNT),
    .RA_W     (RA_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_ra    (cmd_ra),
    .cmd_rb    (cmd_rb),
    .cmd_imm_en(cmd_imm_en),
    .cmd_imm   (cmd_imm),
    .cmd_rd    (cmd_rd),
    .cmd_wb    (cmd_wb),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sl    (alu_sl),
    .alu_su    (alu_su),
    .alu_c     (alu_c),
    .alu_z     (alu_z),
    .alu_s     (alu_s),
    .alu_p     (alu_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {carry, result}. Carry-in for ADC/SBB is flag C.
  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic cin);
    logic [8:0] t;
    case (op)
      4'h0: t = 9'h000;
      4'h1: t = {1'b0, b};
      4'h2: t = {1'b0, ~b};
      4'h3: t = {1'b0, a};
      4'h4: t = {1'b0, ~a};
      4'h5: t = {1'b0, a} + 9'd1;
      4'h6: t = {(a == 8'h00), a - 8'd1};
      4'h7: t = {a[7], a[6:0], 1'b0};
      4'h8: t = {1'b0, a} + {1'b0, b};
      4'h9: t = {1'b0, a} + {1'b0, ~b} + 9'd1;
      4'hA: t = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      4'hB: t = {1'b0, a} + {1'b0, ~b} + {8'd0, cin};
      4'hC: t = {1'b0, a & b};
      4'hD: t = {1'b0, a | b};
      4'hE: t = {1'b0, a ^ b};
      default: t = {1'b0, ~(a ^ b)};
    endcase
    return t;
  endfunction

  assign alu_cs = alu_f(alu_sl, alu_a, alu_b, flags[FLAG_C]);
  assign alu_c  = alu_cs[8];
  assign alu_su = alu_cs[7:0];
  assign alu_z  = (alu_su == 8'h00);
  assign alu_s  = alu_su[7];
  assign alu_p  = ~^alu_su;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] flg;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sl;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mregs[REG_COUNT];
  logic [3:0] mflags;
  logic [7:0] last_data;
  logic [3:0] last_flags;
  int         n_tests;
  int         n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(REG_COUNT); i++) mregs[i] = 8'h00;
    mflags = 4'h0;
    sb.delete();
  endtask

  // Drive one command, compute its expected outcome, return 1ns after accept.
  task automatic send(input logic [3:0] op, input logic [1:0] ra, input logic [1:0] rb,
                      input logic imm_en, input logic [7:0] imm, input logic [1:0] rd,
                      input logic wb);
    int         n;
    exp_t       e;
    logic [8:0] t;
    cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_imm_en = imm_en;
    cmd_imm = imm; cmd_rd = rd; cmd_wb = wb; cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_wait", 32'(n < 20), 32'd1);
    e.a  = mregs[ra];
    e.b  = imm_en ? imm : mregs[rb];
    e.sl = op;
    t    = alu_f(op, e.a, e.b, mflags[FLAG_C]);
    mflags[FLAG_C] = t[8];
    if (op[3]) begin
      mflags[FLAG_Z] = (t[7:0] == 8'h00);
      mflags[FLAG_S] = t[7];
      mflags[FLAG_P] = ~^t[7:0];
    end
    if (wb) mregs[rd] = t[7:0];
    e.data = t[7:0];
    e.flg  = mflags;
    sb.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("exec_alu_a", 32'(alu_a), 32'(e.a));
    chk("exec_alu_b", 32'(alu_b), 32'(e.b));
    chk("exec_alu_sl", 32'(alu_sl), 32'(e.sl));
    chk("exec_no_rsp", 32'(rsp_valid), 32'd0);
  endtask

  // Wait for the response, hold it back for 'hold' cycles, then handshake.
  task automatic get_rsp(input int hold);
    int   n;
    exp_t e;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("rsp_latency", 32'(n), 32'd1);
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rsp_data", 32'(rsp_data), 32'(e.data));
      chk("rsp_flags", 32'(flags), 32'(e.flg));
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk("bp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_data_stable", 32'(rsp_data), 32'(e.data));
        chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      end
    end
    last_data  = rsp_data;
    last_flags = flags;
    rsp_ready  = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_done", 32'(rsp_valid), 32'd0);
    chk("idle_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_ra = '0; cmd_rb = '0;
    cmd_imm_en = 1'b0; cmd_imm = '0; cmd_rd = '0; cmd_wb = 1'b0; rsp_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_alu_in", 32'({alu_a, alu_b, alu_sl}), 32'd0);

    // ADD via immediate
    send(OP_PASSB, 2'd0, 2'd0, 1'b1, 8'hF0, 2'd1, 1'b1); get_rsp(0);
    send(OP_ADD, 2'd1, 2'd0, 1'b1, 8'h20, 2'd2, 1'b1); get_rsp(0);
    chk("add_data", 32'(last_data), 32'h10);
    chk("add_flags", 32'(last_flags), 32'b1000);
    chk("add_r2", 32'(dut.u_regfile.regs[2]), 32'h10);

    // SUB on registers
    send(OP_PASSB, 2'd0, 2'd0, 1'b1, 8'h05, 2'd0, 1'b1); get_rsp(0);
    send(OP_PASSB, 2'd0, 2'd0, 1'b1, 8'h07, 2'd1, 1'b1); get_rsp(0);
    send(OP_SUB, 2'd0, 2'd1, 1'b0, 8'h00, 2'd3, 1'b0); get_rsp(0);
    chk("sub_data", 32'(last_data), 32'hFE);
    chk("sub_flags", 32'(last_flags), 32'b0010);

    // Flag hold for select codes 0-7
    send(OP_INC, 2'd0, 2'd0, 1'b0, 8'h00, 2'd3, 1'b0); get_rsp(0);
    chk("inc_data", 32'(last_data), 32'h06);
    chk("inc_flags", 32'(last_flags), 32'b0010);
    send(OP_PASSB, 2'd0, 2'd0, 1'b1, 8'h80, 2'd3, 1'b1); get_rsp(0);
    send(OP_SHL, 2'd3, 2'd0, 1'b0, 8'h00, 2'd3, 1'b0); get_rsp(0);
    chk("shl_data", 32'(last_data), 32'h00);
    chk("shl_flags_c_only", 32'(last_flags), 32'b1010);

    // ra == rb == rd uses pre-write operands
    send(OP_ADD, 2'd1, 2'd1, 1'b0, 8'h00, 2'd1, 1'b1); get_rsp(0);
    chk("same_reg_data", 32'(last_data), 32'h0E);
    chk("same_reg_r1", 32'(dut.u_regfile.regs[1]), 32'h0E);

    // Write to index 0
    send(OP_PASSB, 2'd0, 2'd0, 1'b1, 8'hA5, 2'd0, 1'b1); get_rsp(0);
    chk("r0_write", 32'(dut.u_regfile.regs[0]), 32'hA5);

    // Backpressure with a second command waiting; it must read the write-back
    send(OP_XOR, 2'd0, 2'd0, 1'b1, 8'hFF, 2'd2, 1'b1);
    cmd_op = OP_PASSA; cmd_ra = 2'd2; cmd_imm_en = 1'b0; cmd_wb = 1'b0; cmd_valid = 1'b1;
    get_rsp(5);
    chk("bp_first_data", 32'(last_data), 32'h5A);
    send(OP_PASSA, 2'd2, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0); get_rsp(0);
    chk("raw_data", 32'(last_data), 32'h5A);

    // Reset during RESP of a write-back command
    send(OP_PASSB, 2'd0, 2'd0, 1'b1, 8'h55, 2'd3, 1'b1);
    @(posedge clk); #1;
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_resp_ready", 32'(cmd_ready), 32'd1);
    chk("rst_resp_flags", 32'(flags), 32'd0);
    chk("rst_resp_data", 32'(rsp_data), 32'd0);
    for (int i = 0; i < int'(REG_COUNT); i++) begin
      chk("rst_resp_reg", 32'(dut.u_regfile.regs[2'(i)]), 32'd0);
    end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Operation after reset sees cleared registers
    send(OP_ADD, 2'd3, 2'd0, 1'b1, 8'h00, 2'd0, 1'b0); get_rsp(0);
    chk("post_rst_data", 32'(last_data), 32'h00);
    chk("post_rst_flags", 32'(last_flags), 32'b0101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
